// File: rtl/alsu_gen.sv
// alsu_gen -- arithmetic/logic/shift unit with a valid/ready handshake.
//   Single-cycle ops (OR, XOR, ADD, SHIFT, ROTATE, bypass, invalid) load
//   out on the accept edge. MUL runs an iterative shift-add for WIDTH cycles.
//   The result is then held until out_ready is seen.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  request handshake (in_ready = IDLE)
//   A, B, opcode         operands; 0 OR, 1 XOR, 2 ADD, 3 MUL, 4 SHIFT, 5 ROTATE
//   cin, serial_in, direction, red_op_A/B, bypass_A/B   op modifiers
//   out / out_valid / out_ready   result register and handshake
//   leds                 toggles every cycle after an invalid op
//   flags (optional)     {carry, zero}; present only with ALSU_GEN_FLAGS_EN
// Optional feature macro: ALSU_GEN_FLAGS_EN
module alsu_gen #(
  parameter int WIDTH          = 4,
  parameter     INPUT_PRIORITY = "A",
  parameter     FULL_ADDER     = "ON",
  parameter int LED_W          = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         opcode,
  input  logic               cin,
  input  logic               serial_in,
  input  logic               direction,
  input  logic               red_op_A,
  input  logic               red_op_B,
  input  logic               bypass_A,
  input  logic               bypass_B,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LED_W-1:0]   leds
`ifdef ALSU_GEN_FLAGS_EN
  ,
  output logic [1:0]         flags
`endif
);
  localparam int OW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
  state_t state, state_nxt;

  logic             accept;
  logic [WIDTH-1:0] pri, red_sel;
  logic [WIDTH:0]   sum;
  logic             cin_eff;
  logic [OW-1:0]    res;
  logic             res_carry, invalid, is_mul;

  // shift-add multiplier state
  logic [OW-1:0]    acc, mcand, acc_nxt;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             inv_active;

  assign accept  = in_valid && in_ready;
  assign pri     = (INPUT_PRIORITY == "A") ? A : B;
  assign red_sel = (red_op_A && red_op_B) ? pri : (red_op_A ? A : B);
  assign cin_eff = (FULL_ADDER == "ON") ? cin : 1'b0;
  assign sum     = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cin_eff};
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Single-cycle result, evaluated from the live inputs on the accept edge.
  always_comb begin
    res       = '0;
    res_carry = 1'b0;
    invalid   = 1'b0;
    is_mul    = 1'b0;
    if (bypass_A || bypass_B) begin
      res = {{WIDTH{1'b0}}, (bypass_A && bypass_B) ? pri : (bypass_A ? A : B)};
    end else if (((red_op_A || red_op_B) && opcode > 3'd1) || opcode > 3'd5) begin
      invalid = 1'b1;
    end else begin
      case (opcode)
        3'd0: res = (red_op_A || red_op_B) ? {{(OW-1){1'b0}}, |red_sel}
                                           : {{WIDTH{1'b0}}, A | B};
        3'd1: res = (red_op_A || red_op_B) ? {{(OW-1){1'b0}}, ^red_sel}
                                           : {{WIDTH{1'b0}}, A ^ B};
        3'd2: begin
          res       = {{(WIDTH-1){1'b0}}, sum};
          res_carry = sum[WIDTH];
        end
        3'd3: is_mul = 1'b1;
        3'd4: res = direction ? {out[OW-2:0], serial_in} : {serial_in, out[OW-1:1]};
        3'd5: res = direction ? {out[OW-2:0], out[OW-1]} : {out[0], out[OW-1:1]};
        default: res = '0;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_mul ? MUL : HOLD;
      MUL:     if (cnt == LAST) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
  end

  // Datapath. out is untouched while MUL iterates, so the old value stays visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      out        <= '0;
      leds       <= '0;
      inv_active <= 1'b0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
`ifdef ALSU_GEN_FLAGS_EN
      flags      <= 2'b00;
`endif
    end else begin
      if (accept) begin
        inv_active <= invalid;
        // An invalid op starts the toggle on its own accept edge.
        // A valid op clears the toggle.
        leds       <= invalid ? ~leds : '0;
        if (is_mul) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, A};
          mplier <= B;
          cnt    <= '0;
        end else begin
          out <= res;
`ifdef ALSU_GEN_FLAGS_EN
          flags <= {res_carry, res == '0};
`endif
        end
      end else if (inv_active) begin
        leds <= ~leds;
      end

      if (state == MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == LAST) begin
          out <= acc_nxt;
`ifdef ALSU_GEN_FLAGS_EN
          flags <= {1'b0, acc_nxt == '0};
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_alsu_gen.sv
// Directed bench for alsu_gen (WIDTH=4, defaults).
module tb_alsu_gen;
  localparam int W = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] A = '0, B = '0;
  logic [2:0] opcode = '0;
  logic cin = 0, serial_in = 0, direction = 0;
  logic red_op_A = 0, red_op_B = 0, bypass_A = 0, bypass_B = 0;
  logic [2*W-1:0] out;
  logic out_valid, out_ready = 1'b0;
  logic [15:0] leds;
`ifdef ALSU_GEN_FLAGS_EN
  logic [1:0] flags;
`endif
  int tests = 0, fails = 0;

  alsu_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
    .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
    .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .leds(leds)
`ifdef ALSU_GEN_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // present one request across a single edge
  task automatic fire();
    in_valid = 1'b1; step(); in_valid = 1'b0;
  endtask

  task automatic release_hold();
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
  endtask

  task automatic set_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    opcode = op; A = a; B = b;
  endtask

  initial begin
    int n;
    step(); step();
    rst = 1'b0;
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_leds", leds, 0);

    // ADD 15+1+1 = 17, latency 1
    set_op(3'd2, 4'd15, 4'd1); cin = 1; fire(); cin = 0;
    chk("add_out", out, 17);
    chk("add_valid", out_valid, 1);
    chk("add_in_ready", in_ready, 0);
`ifdef ALSU_GEN_FLAGS_EN
    chk("add_flags", flags, 2'b10);
`endif
    release_hold();

    // MUL 13*11 = 143, out_valid 5 edges after accept
    set_op(3'd3, 4'd13, 4'd11); fire(); set_op(3'd0, 4'd0, 4'd0);
    n = 1;
    while (!out_valid && n < 20) begin
      chk("mul_in_ready_low", in_ready, 0);
      chk("mul_out_held", out, 17);
      step(); n++;
    end
    chk("mul_latency", n, 5);
    chk("mul_out", out, 143);
    chk("mul_in_ready_hold", in_ready, 0);
    release_hold();

    // invalid opcode 6: out=0, leds toggle
    set_op(3'd6, 4'd5, 4'd5); fire();
    chk("inv_out", out, 0);
    chk("inv_leds0", leds, 16'hFFFF);
    step(); chk("inv_leds1", leds, 16'h0000);
    step(); chk("inv_leds2", leds, 16'hFFFF);
    release_hold();
    chk("inv_leds3", leds, 16'h0000);
    set_op(3'd0, 4'd3, 4'd4); fire();
    chk("or_out", out, 7);
    chk("or_leds_clear", leds, 0);
    step(); chk("or_leds_stay", leds, 0);
    release_hold();

    // XOR 5^3 = 6
    set_op(3'd1, 4'd5, 4'd3); fire();
    chk("xor_out", out, 6);
    release_hold();

    // XOR reduction of A=7 -> 1
    set_op(3'd1, 4'd7, 4'd0); red_op_A = 1; fire(); red_op_A = 0;
    chk("xor_red_A", out, 1);
    release_hold();

    // OR reduction, both flags: A wins, |0 = 0
    set_op(3'd0, 4'd0, 4'd5); red_op_A = 1; red_op_B = 1; fire();
    red_op_A = 0; red_op_B = 0;
    chk("or_red_pri", out, 0);
    release_hold();

    // red_op with ADD is invalid
    set_op(3'd2, 4'd3, 4'd3); red_op_B = 1; fire(); red_op_B = 0;
    chk("red_add_inv_out", out, 0);
    chk("red_add_inv_leds", leds, 16'hFFFF);
    release_hold();

    // both bypass on an invalid opcode: A wins, leds cleared
    set_op(3'd7, 4'd9, 4'd6); bypass_A = 1; bypass_B = 1; fire();
    chk("byp_both", out, 9);
    chk("byp_leds", leds, 0);
    release_hold();
    set_op(3'd1, 4'd9, 4'd3); bypass_B = 1; bypass_A = 0; fire(); bypass_B = 0;
    chk("byp_B", out, 3);
    release_hold();

    // shift right of 0x03 with serial_in=1 -> 0x81
    set_op(3'd4, 4'd0, 4'd0); direction = 0; serial_in = 1; fire();
    chk("shr_out", out, 8'h81);
    release_hold();
    direction = 1; serial_in = 0; fire();
    chk("shl_out", out, 8'h02);
    release_hold();
    set_op(3'd5, 4'd0, 4'd0); direction = 0; fire();
    chk("rotr_out", out, 8'h01);
    release_hold();
    fire();
    chk("rotr_wrap", out, 8'h80);
    release_hold();
    direction = 1; fire();
    chk("rotl_wrap", out, 8'h01);
    release_hold();

    // HOLD: 10 cycles with out_ready low, in_valid ignored
    set_op(3'd2, 4'd2, 4'd3); fire();
    chk("hold_add", out, 5);
    set_op(3'd0, 4'd15, 4'd15); in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_out", out, 5);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 0;
    release_hold();
    chk("hold_out_after", out, 5);

    // reset two cycles into a MUL
    set_op(3'd3, 4'd13, 4'd11); fire(); step(); step();
    rst = 1; step(); rst = 0;
    chk("mrst_out", out, 0);
    chk("mrst_valid", out_valid, 0);
    chk("mrst_in_ready", in_ready, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid || out != 0) n++;
    end
    chk("mrst_no_result", n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alsu_gen.md
ALSU_GEN -- requirements
Module: alsu_gen

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits (legal range 2..16).
REQ-002 Parameter INPUT_PRIORITY, default "A", selects operand when both bypass or both red_op flags are set.
REQ-003 Parameter FULL_ADDER, default "ON", adds cin to the ADD result when "ON".
REQ-004 Parameter LED_W, default 16, width of leds.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request
- A, B  in  WIDTH  operands
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MUL, 4 SHIFT, 5 ROTATE
- cin, serial_in, direction  in  1  carry-in; shift-in bit; 1 = left, 0 = right
- red_op_A, red_op_B, bypass_A, bypass_B  in  1  reduction and bypass controls
- out  out  2*WIDTH  result register
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- leds  out  LED_W  invalid-operation indicator

Function
REQ-006 The FSM SHALL have the states IDLE, MUL, HOLD; in_ready SHALL equal (state==IDLE).
REQ-007 Accept = in_valid && in_ready; all inputs SHALL be captured only on accept and ignored otherwise.
REQ-008 Bypass SHALL take precedence over opcode: both set -> operand per INPUT_PRIORITY; one set -> that operand, zero-extended to 2*WIDTH.
REQ-009 Invalid = ((red_op_A|red_op_B) && opcode not in {0,1}) || opcode in {6,7}; bypass SHALL override invalid.
REQ-010 Invalid op: out SHALL load 0; leds SHALL invert every cycle from the accept onward until the next accepted valid op, which SHALL clear leds to 0 in its load cycle.
REQ-011 OR/XOR with red_op SHALL return the 1-bit reduction of the selected operand (INPUT_PRIORITY when both are set), zero-extended; otherwise the bitwise op on A and B, zero-extended.
REQ-012 ADD SHALL produce a WIDTH+1-bit sum (A+B, plus cin if FULL_ADDER=="ON"), zero-extended.
REQ-013 SHIFT SHALL shift the current out by one bit and insert serial_in: left = {out[2W-2:0],serial_in}; right = {serial_in,out[2W-1:1]}.
REQ-014 ROTATE SHALL rotate the current out by one bit in the direction selected by direction.
REQ-015 Single-cycle ops: out loads on the accept edge; state goes to HOLD; out_valid is high from the next cycle (latency 1).
REQ-016 MUL SHALL run as an iterative shift-add in state MUL for exactly WIDTH cycles after the accept; it then loads out = A*B (full 2*WIDTH bits) and goes to HOLD; latency WIDTH+1.
REQ-017 During MUL, out SHALL keep its previous value and out_valid SHALL be 0.
REQ-018 In HOLD, out_valid=1 and out stays stable; on out_ready the state SHALL return to IDLE, with in_ready=1 in the following cycle.
REQ-019 out_valid and in_ready SHALL never be high in the same cycle.

Reset
REQ-020 When rst=1 at a clock edge: state=IDLE; out=0, out_valid=0, leds=0, all captured registers=0; in_ready=1 after the edge.
REQ-021 Reset SHALL take priority over every event, including a MUL in progress and a held result; the aborted result SHALL never be presented.

Configuration
REQ-022 Macro ALSU_GEN_FLAGS_EN defined: add output flags[1:0] = {carry, zero}; zero = (out==0); carry = ADD sum bit WIDTH, else 0; flags registered with out, reset to 0.
REQ-023 Macro undefined: the flags port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-024 WIDTH=4, ADD A=15 B=1 cin=1 FULL_ADDER="ON" -> out=17 one cycle after accept; flags=2'b10 when enabled.
REQ-025 MUL A=13 B=11 -> out_valid 5 cycles after accept, out=143; in_ready=0 throughout.
REQ-026 opcode=6 accepted -> out=0 and leds alternate 0xFFFF/0x0000 each cycle; next valid OR A=3 B=4 -> leds=0, out=7.
REQ-027 out=8'h81, SHIFT left serial_in=0 -> 8'h02; then ROTATE right -> 8'h01.
REQ-028 rst asserted 2 cycles into a MUL -> out=0, out_valid=0, in_ready=1 on the next cycle; no result is ever presented.
REQ-029 out_ready held 0 for 10 cycles in HOLD -> out stable, in_valid ignored; out_ready=1 -> IDLE.
